// File: rtl/time_setter_if.sv
// Control/display bundle between the time_setter and its surrounding logic.
// The master drives the user inputs; the slave (time_setter) drives the outputs.
interface time_setter_if;
    logic        mode_switch;
    logic        sel;
    logic        inc;
    logic        dec;
    logic [12:0] q_target;
    logic [7:0]  min_bcd;
    logic [7:0]  sec_bcd;
    logic        field;
    logic        editing;
    logic        blink;
    logic        load_pulse;

    modport master (
        output mode_switch, sel, inc, dec,
        input  q_target, min_bcd, sec_bcd, field, editing, blink, load_pulse
    );

    modport slave (
        input  mode_switch, sel, inc, dec,
        output q_target, min_bcd, sec_bcd, field, editing, blink, load_pulse
    );
endinterface

// File: rtl/time_setter.sv
// Target-time editor: BCD minutes/seconds adjusted with inc/dec taps and
// hold-to-repeat, field select, blink strobe, and a reload pulse on exit.
module time_setter #(
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned BLINK_CYCLES  = 25000000
) (
    input  logic         clk,
    input  logic         rst,
    time_setter_if.slave bus
);

    localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);
    localparam logic [31:0] BLINK_LAST  = 32'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {RUN, EDIT, HOLD_WAIT, REPEAT} state_t;

    state_t      r_state;
    logic [7:0]  r_min;
    logic [7:0]  r_sec;
    logic        r_field;
    logic        r_editing;
    logic        r_blink;
    logic        r_load;
    logic        r_prev_inc;
    logic        r_prev_dec;
    logic        r_dir_up;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_blink_cnt;

    logic        w_rise_inc;
    logic        w_rise_dec;
    logic        w_held;
    logic        w_step;
    logic        w_up;

    // Wraps inside {top,9}..00 without ever producing an illegal nibble.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [3:0] top);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (up) begin
            if (hi == top && lo == 4'd9) return '0;
            if (lo == 4'd9)              return {hi + 4'd1, 4'd0};
            return {hi, lo + 4'd1};
        end
        if (v == 8'h00)  return {top, 4'd9};
        if (lo == 4'd0)  return {hi - 4'd1, 4'd9};
        return {hi, lo - 4'd1};
    endfunction

    assign w_rise_inc = bus.inc & ~r_prev_inc;
    assign w_rise_dec = bus.dec & ~r_prev_dec;
    // Holding is only valid for the button that started it, and never with both pressed.
    assign w_held     = (r_dir_up ? bus.inc : bus.dec) & ~(bus.inc & bus.dec);

    always_comb begin
        w_step = 1'b0;
        w_up   = r_dir_up;
        if (bus.mode_switch) begin
            case (r_state)
                EDIT: begin
                    if (w_rise_inc && !bus.dec) begin
                        w_step = 1'b1;
                        w_up   = 1'b1;
                    end else if (w_rise_dec && !bus.inc) begin
                        w_step = 1'b1;
                        w_up   = 1'b0;
                    end
                end
                HOLD_WAIT: w_step = w_held && (r_hold_cnt == HOLD_LAST);
                REPEAT:    w_step = w_held && (r_hold_cnt == REPEAT_LAST);
                default:   w_step = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_min       <= 8'h00;
            r_sec       <= 8'h30;
            r_field     <= 1'b0;
            r_editing   <= 1'b0;
            r_blink     <= 1'b0;
            r_load      <= 1'b0;
            r_prev_inc  <= 1'b0;
            r_prev_dec  <= 1'b0;
            r_dir_up    <= 1'b0;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_prev_inc <= bus.inc;
            r_prev_dec <= bus.dec;
            r_load     <= 1'b0;

            // Step uses the pre-toggle field when sel arrives in the same cycle.
            if (w_step) begin
                if (r_field) r_min <= bcd_step(r_min, w_up, 4'd9);
                else         r_sec <= bcd_step(r_sec, w_up, 4'd5);
            end

            case (r_state)
                RUN: begin
                    if (bus.mode_switch) begin
                        r_state   <= EDIT;
                        r_editing <= 1'b1;
                    end
                end
                default: begin
                    if (!bus.mode_switch) begin
                        r_state     <= RUN;
                        r_editing   <= 1'b0;
                        r_load      <= 1'b1;
                        r_blink     <= 1'b0;
                        r_blink_cnt <= '0;
                        r_hold_cnt  <= '0;
                    end else begin
                        if (bus.sel) r_field <= ~r_field;

                        if (w_step || bus.sel) begin
                            r_blink     <= 1'b0;
                            r_blink_cnt <= '0;
                        end else if (r_blink_cnt == BLINK_LAST) begin
                            r_blink     <= ~r_blink;
                            r_blink_cnt <= '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 32'd1;
                        end

                        case (r_state)
                            EDIT: begin
                                if (w_step) begin
                                    r_state    <= HOLD_WAIT;
                                    r_dir_up   <= w_up;
                                    r_hold_cnt <= '0;
                                end
                            end
                            HOLD_WAIT: begin
                                if (!w_held) begin
                                    r_state    <= EDIT;
                                    r_hold_cnt <= '0;
                                end else if (r_hold_cnt == HOLD_LAST) begin
                                    r_state    <= REPEAT;
                                    r_hold_cnt <= '0;
                                end else begin
                                    r_hold_cnt <= r_hold_cnt + 32'd1;
                                end
                            end
                            REPEAT: begin
                                if (!w_held) begin
                                    r_state    <= EDIT;
                                    r_hold_cnt <= '0;
                                end else if (r_hold_cnt == REPEAT_LAST) begin
                                    r_hold_cnt <= '0;
                                end else begin
                                    r_hold_cnt <= r_hold_cnt + 32'd1;
                                end
                            end
                            default: r_state <= RUN;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.q_target   = 13'(r_min[7:4]) * 13'd600 + 13'(r_min[3:0]) * 13'd60
                          + 13'(r_sec[7:4]) * 13'd10  + 13'(r_sec[3:0]);
    assign bus.min_bcd    = r_min;
    assign bus.sec_bcd    = r_sec;
    assign bus.field      = r_field;
    assign bus.editing    = r_editing;
    assign bus.blink      = r_blink;
    assign bus.load_pulse = r_load;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: stimulus queues expected display changes
// and reload pulses with their cycle stamps; a negedge monitor pops and compares.
module tb_time_setter;

    localparam int unsigned HOLD   = 10;
    localparam int unsigned REP    = 4;
    localparam int unsigned BLINKC = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic [15:0] last_disp = {8'h00, 8'h30};

    typedef struct {
        logic [7:0] sec;
        logic [7:0] min;
        int         q;
        int         cyc;
    } exp_t;

    exp_t q_exp[$];
    int   q_load[$];

    time_setter_if u_if ();

    time_setter #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .BLINK_CYCLES (BLINKC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic push_exp(input int s, input int m, input int c);
        exp_t e;
        e.sec = to_bcd(s);
        e.min = to_bcd(m);
        e.q   = m * 60 + s;
        e.cyc = c;
        q_exp.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tap(input bit up, input int s, input int m);
        if (up) u_if.inc = 1'b1; else u_if.dec = 1'b1;
        push_exp(s, m, cyc + 1);
        tick(1);
        u_if.inc = 1'b0;
        u_if.dec = 1'b0;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if ({u_if.min_bcd, u_if.sec_bcd} != last_disp) begin
                last_disp = {u_if.min_bcd, u_if.sec_bcd};
                if (q_exp.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_step actual=min %h sec %h expected=no change (cycle %0d)",
                             u_if.min_bcd, u_if.sec_bcd, cyc);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("sec_bcd",  int'(u_if.sec_bcd), int'(e.sec));
                    chk("min_bcd",  int'(u_if.min_bcd), int'(e.min));
                    chk("q_target", int'(u_if.q_target), e.q);
                    chk("step_cycle", cyc, e.cyc);
                end
            end
            if (u_if.load_pulse) begin
                if (q_load.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_load actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    chk("load_cycle", cyc, q_load.pop_front());
                end
            end
        end
    end

    initial begin
        int p;
        u_if.mode_switch = 1'b0;
        u_if.sel = 1'b0;
        u_if.inc = 1'b0;
        u_if.dec = 1'b0;
        #1 rst = 1'b0;
        tick(3);

        chk("rst_sec",     int'(u_if.sec_bcd), 8'h30);
        chk("rst_min",     int'(u_if.min_bcd), 8'h00);
        chk("rst_q",       int'(u_if.q_target), 30);
        chk("rst_field",   int'(u_if.field), 0);
        chk("rst_editing", int'(u_if.editing), 0);
        chk("rst_blink",   int'(u_if.blink), 0);
        chk("rst_load",    int'(u_if.load_pulse), 0);
        mon_en = 1'b1;
        rst = 1'b1;
        tick(1);

        // Enter setting mode and tap inc on seconds.
        u_if.mode_switch = 1'b1;
        tick(1);
        chk("edit_entry", int'(u_if.editing), 1);
        chk("edit_blink", int'(u_if.blink), 0);
        tap(1'b1, 31, 0);
        chk("edit_after_tap", int'(u_if.editing), 1);

        for (int s = 32; s <= 59; s++) tap(1'b1, s, 0);
        tap(1'b1, 0, 0);

        // Minutes field: 00 - 1 wraps to 99.
        u_if.sel = 1'b1;
        tick(1);
        u_if.sel = 1'b0;
        chk("field_min", int'(u_if.field), 1);
        tap(1'b0, 0, 99);
        tick(4);
        chk("blink_low", int'(u_if.blink), 0);
        tick(1);
        chk("blink_high", int'(u_if.blink), 1);

        // Simultaneous inc/dec rise: no step.
        u_if.inc = 1'b1;
        u_if.dec = 1'b1;
        tick(2);
        u_if.inc = 1'b0;
        u_if.dec = 1'b0;
        tick(1);
        chk("both_field", int'(u_if.field), 1);

        // sel with inc in the same cycle steps the pre-toggle field.
        u_if.sel = 1'b1;
        tick(1);
        u_if.sel = 1'b0;
        chk("field_sec", int'(u_if.field), 0);
        tick(2);
        u_if.sel = 1'b1;
        u_if.inc = 1'b1;
        push_exp(1, 99, cyc + 1);
        tick(1);
        u_if.sel = 1'b0;
        u_if.inc = 1'b0;
        chk("sel_inc_field", int'(u_if.field), 1);
        chk("sel_inc_blink", int'(u_if.blink), 0);
        tick(1);
        u_if.sel = 1'b1;
        tick(1);
        u_if.sel = 1'b0;
        tick(1);

        // Hold inc 30 cycles: steps at press, +10, +14, +18, +22, +26.
        p = cyc + 1;
        push_exp(2, 99, p);
        push_exp(3, 99, p + 10);
        push_exp(4, 99, p + 14);
        push_exp(5, 99, p + 18);
        push_exp(6, 99, p + 22);
        push_exp(7, 99, p + 26);
        u_if.inc = 1'b1;
        tick(30);
        u_if.inc = 1'b0;
        tick(5);
        chk("hold_editing", int'(u_if.editing), 1);

        // Raising dec during REPEAT aborts the hold without a step.
        p = cyc + 1;
        push_exp(8, 99, p);
        push_exp(9, 99, p + 10);
        u_if.inc = 1'b1;
        tick(12);
        u_if.dec = 1'b1;
        tick(8);
        u_if.inc = 1'b0;
        u_if.dec = 1'b0;
        tick(2);

        // Leaving setting mode mid-REPEAT.
        p = cyc + 1;
        push_exp(10, 99, p);
        push_exp(11, 99, p + 10);
        u_if.inc = 1'b1;
        tick(12);
        u_if.mode_switch = 1'b0;
        q_load.push_back(cyc + 1);
        tick(3);
        chk("run_editing", int'(u_if.editing), 0);
        chk("run_blink",   int'(u_if.blink), 0);
        u_if.inc = 1'b0;
        tick(1);
        u_if.inc = 1'b1;
        tick(1);
        u_if.inc = 1'b0;
        u_if.sel = 1'b1;
        tick(1);
        u_if.sel = 1'b0;
        tick(1);
        chk("run_q_stable", int'(u_if.q_target), 5951);
        chk("run_field",    int'(u_if.field), 0);

        // Asynchronous reset during a hold.
        u_if.mode_switch = 1'b1;
        tick(1);
        chk("reenter_editing", int'(u_if.editing), 1);
        u_if.inc = 1'b1;
        push_exp(12, 99, cyc + 1);
        tick(5);
        rst = 1'b0;
        push_exp(30, 0, cyc);
        tick(12);
        chk("rst_hold_editing", int'(u_if.editing), 0);
        chk("rst_hold_field",   int'(u_if.field), 0);
        rst = 1'b1;
        tick(1);
        chk("post_rst_editing", int'(u_if.editing), 1);
        tick(3);
        u_if.inc = 1'b0;
        tick(2);
        tap(1'b0, 29, 0);

        u_if.mode_switch = 1'b0;
        q_load.push_back(cyc + 1);
        tick(3);
        chk("final_editing", int'(u_if.editing), 0);
        chk("exp_queue_empty",  q_exp.size(), 0);
        chk("load_queue_empty", q_load.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
